// File: rtl/jt7759_dfetch_if.sv
// ROM fetch bus between the jt7759 data fetcher (master) and the sample ROM (slave).
interface jt7759_dfetch_if #(
   parameter int DW = 8,
   parameter int AW = 17
);
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          rom_ok;

   modport master (output rom_cs, rom_addr, input rom_data, rom_ok);
   modport slave  (input rom_cs, rom_addr, output rom_data, rom_ok);
endinterface

// File: rtl/jt7759_dfetch.sv
// jt7759 sample data fetcher: small FIFO refilled from ROM (master mode) or
// host writes (slave mode), drained one byte per consumer read request.
module jt7759_dfetch #(
   parameter int DW         = 8,
   parameter int AW         = 17,
   parameter int DEPTH_LOG2 = 2,
   parameter int LOWAT      = 1,
   parameter int GAPW       = 5
) (
   input  logic                  rst,
   input  logic                  clk,
   input  logic                  cen_ctl,
   input  logic                  mdn,
   input  logic                  ctrl_flush,
   input  logic                  ctrl_cs,
   input  logic                  ctrl_busyn,
   input  logic [AW-1:0]         ctrl_addr,
   output logic [DW-1:0]         ctrl_din,
   output logic                  ctrl_ok,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  ovf,
   jt7759_dfetch_if.master       rom,
   input  logic                  cs,
   input  logic                  wrn,
   input  logic [DW-1:0]         din,
   output logic                  drqn
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LOW   = (DEPTH_LOG2+1)'(LOWAT);
   localparam logic [DEPTH_LOG2:0]   LVL1  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR1  = DEPTH_LOG2'(1);

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t                state, state_nx;
   logic [DW-1:0]         mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [AW-1:0]         addr;
   logic [GAPW-1:0]       gap;
   logic                  fill_q, fill_now;
   logic                  drqn_l, rd_pend, cs_l;
   logic                  full, halt, accept, wr_en, rd_en, drop;
   logic [DW-1:0]         wr_byte;

   assign rom.rom_cs   = mdn & ~drqn;
   assign rom.rom_addr = addr;

   // Datapath decode: fill hysteresis, accept/drop/read qualification
   always_comb begin
      full     = (level == FULL);
      halt     = ctrl_flush | ctrl_busyn;
      drqn     = (state == ST_IDLE);
      fill_now = fill_q;
      if (level <= LOW)
         fill_now = 1'b1;
      else if (full)
         fill_now = 1'b0;
      accept = 1'b0;
      // master accept needs drqn low for two cycles, hence drqn_l
      if (!halt && state == ST_REQ)
         accept = mdn ? (rom.rom_ok & ~drqn_l) : (cs & ~wrn);
      wr_en   = accept & ~full;
      wr_byte = mdn ? rom.rom_data : din;
      drop    = ~mdn & cs & ~wrn & full;
      rd_en   = rd_pend & ctrl_cs & (level != '0) & ~halt;
   end

   // Request FSM next state: idle (drqn high) or transfer pending (drqn low)
   always_comb begin
      state_nx = state;
      if (halt)
         state_nx = ST_IDLE;
      else begin
         case (state)
            ST_IDLE: if (fill_now && gap == '0) state_nx = ST_REQ;
            ST_REQ:  if (accept || full)        state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // Request FSM state register and previous-cycle drqn
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         drqn_l <= 1'b1;
      end else begin
         state  <= state_nx;
         drqn_l <= drqn;
      end
   end

   // FIFO pointers, occupancy, overflow flag and ROM address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         fill_q <= 1'b1;
         ovf    <= 1'b0;
         addr   <= '0;
      end else begin
         fill_q <= fill_now;
         if (ctrl_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            addr   <= ctrl_addr;
         end else if (ctrl_busyn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            if (drop) ovf <= 1'b1;
         end else begin
            if (drop) ovf <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + PTR1;
            if (wr_en && mdn) addr <= addr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR1;
            case ({wr_en, rd_en})
               2'b10:   level <= level + LVL1;
               2'b01:   level <= level - LVL1;
               default: level <= level;
            endcase
         end
      end
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_byte;
   end

   // Minimum spacing between requests: reload on accept, count down on cen_ctl
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gap <= '0;
      else if (accept)
         gap <= '1;
      else if (cen_ctl && gap != '0)
         gap <= gap - GAPW'(1);
   end

   // Consumer side: read request on ctrl_cs rising edge, served when data is present
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_din <= '0;
         ctrl_ok  <= 1'b0;
         rd_pend  <= 1'b0;
         cs_l     <= 1'b0;
      end else begin
         cs_l <= ctrl_cs;
         if (!ctrl_cs) begin
            ctrl_ok <= 1'b0;
            rd_pend <= 1'b0;
         end else if (!cs_l) begin
            ctrl_ok <= 1'b0;
            rd_pend <= 1'b1;
         end else if (rd_en) begin
            ctrl_din <= mem[rd_ptr];
            ctrl_ok  <= 1'b1;
            rd_pend  <= 1'b0;
         end
      end
   end
endmodule

// File: doc/jt7759_dfetch.md
JT7759_DFETCH -- requirements
Module: jt7759_dfetch

Interface
REQ-001 Parameter DW, default 8, data byte width.
REQ-002 Parameter AW, default 17, ROM address width.
REQ-003 Parameter DEPTH_LOG2, default 2, FIFO depth = 2**DEPTH_LOG2 entries, legal range 1..5.
REQ-004 Parameter LOWAT, default 1, refill threshold in entries, legal range 0..DEPTH-1.
REQ-005 Parameter GAPW, default 5, width of the minimum-spacing counter between requests.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 cen_ctl  in  1  clock enable for the spacing counter.
REQ-009 mdn  in  1  1 = ROM master mode, 0 = slave (host write) mode.
REQ-010 ctrl_flush  in  1  flush FIFO and load rom_addr.
REQ-011 ctrl_cs  in  1  consumer read request; level-held.
REQ-012 ctrl_busyn  in  1  0 = playback active, 1 = idle.
REQ-013 ctrl_addr  in  AW  start address loaded on flush.
REQ-014 ctrl_din  out  DW  byte delivered to the consumer.
REQ-015 ctrl_ok  out  1  ctrl_din valid.
REQ-016 level  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-017 ovf  out  1  sticky: slave write arrived while FIFO full.
REQ-018 rom_cs  out  1  ROM select, = mdn & ~drqn.
REQ-019 rom_addr  out  AW  ROM byte address.
REQ-020 rom_data  in  DW  ROM read data.
REQ-021 rom_ok  in  1  rom_data valid.
REQ-022 cs, wrn  in  1 each  slave write strobe; a write is cs & ~wrn.
REQ-023 din  in  DW  slave write data.
REQ-024 drqn  out  1  data request, active-low.

Function
REQ-025 The FIFO shall be a circular buffer with wrapping read/write pointers; level shall always equal writes minus reads since the last clear.
REQ-026 A fill flag shall be set when level<=LOWAT and cleared when level==DEPTH (hysteresis); drqn may fall only while the fill flag is set.
REQ-027 drqn shall fall when all of the following hold: ctrl_busyn=0, fill flag set, no transfer pending, spacing counter==0.
REQ-028 On drqn falling, a transfer shall be pending; drqn shall return high on the cycle after the transfer is accepted, or immediately when level reaches DEPTH.
REQ-029 Master accept condition: rom_ok=1 while drqn is low in both the current and the previous cycle.
REQ-030 Slave accept condition: cs&~wrn=1 while a transfer is pending.
REQ-031 An accepted byte (rom_data or din, selected by mdn) shall be written at the write pointer, incrementing level, the write pointer and, in master mode, rom_addr (modulo 2**AW).
REQ-032 A slave write with level==DEPTH shall be dropped and shall set ovf; ovf shall clear only on reset or ctrl_flush.
REQ-033 The spacing counter shall reload to all ones on any accept and decrement by 1 on each cen_ctl while nonzero.
REQ-034 On a ctrl_cs rising edge, ctrl_ok shall clear and a read shall be pending.
REQ-035 While a read is pending and level>0, the FIFO head shall be placed on ctrl_din with ctrl_ok=1 on the next edge, the read pointer shall advance and level shall decrement.
REQ-036 With level==0, the read shall wait with ctrl_ok=0 until data arrives; an accepted byte reaches ctrl_din no earlier than one cycle after its write.
REQ-037 ctrl_cs=0 shall clear ctrl_ok and cancel any pending read.
REQ-038 On a simultaneous accept and read in one cycle, level shall be unchanged.
REQ-039 On ctrl_flush, the pointers shall clear, level shall clear, the pending transfer shall cancel, ovf shall clear and rom_addr shall load ctrl_addr; flush takes priority over a same-cycle accept or increment.
REQ-040 ctrl_busyn=1 shall hold drqn=1 and clear the pointers and level; rom_addr shall hold.

Reset
REQ-041 During rst, the outputs shall be drqn=1, rom_cs=0, ctrl_ok=0, ctrl_din=0, level=0, ovf=0 and rom_addr=0, with the pointers, spacing counter and pending flags cleared.
REQ-042 Deassertion of rst mid-transfer shall resume from the idle state; no partial byte is retained.

Verification
REQ-043 Master fill: mdn=1, flush with ctrl_addr=0x1FFFE, busyn=0, rom_ok always 1 -> 4 bytes are fetched from 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; level=4; drqn stays high.
REQ-044 Hysteresis: DEPTH=4, LOWAT=1, full FIFO, 2 reads -> no drqn; 3rd read (level=1) -> drqn falls after the spacing counter expires.
REQ-045 Slave overflow: mdn=0, FIFO full, write of 0xA5 -> ovf=1, level=4, 0xA5 is never delivered; flush -> ovf=0.
REQ-046 Empty read: level=0, ctrl_cs rises -> ctrl_ok=0 until the first accept; ctrl_ok=1 with that byte one cycle later.
REQ-047 Simultaneous read and accept at level=2 -> level=2 and the byte order is preserved.
REQ-048 busyn rises mid-transfer -> drqn=1 in the next cycle and level=0; the late rom_ok is ignored.
